// File: rtl/dst_stream_reader_if.sv
// Port bundle for the destination-buffer stream reader: control, buffer read port
// and output stream.
interface dst_stream_reader_if #(
    parameter int AW = 11,
    parameter int DW = 64
);
    logic          start;
    logic [AW:0]   len;
    logic          busy;
    logic          done;
    logic          dst_v;
    logic [AW-1:0] dst_a;
    logic [DW-1:0] dst_d;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;

    modport slave (
        input  start, len, dst_d, m_ready,
        output busy, done, dst_v, dst_a, m_data, m_valid, m_last
    );

    modport master (
        output start, len, dst_d, m_ready,
        input  busy, done, dst_v, dst_a, m_data, m_valid, m_last
    );
endinterface

// File: rtl/dst_stream_reader.sv
// Walks result-buffer addresses 0..len-1 through a 1-cycle-latency read port and
// re-times the words into a valid/ready stream with a last flag.
module dst_stream_reader #(
    parameter int AW = 11,
    parameter int DW = 64
) (
    input  logic            clk,
    input  logic            rst,
    dst_stream_reader_if.slave bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    localparam logic [AW:0] LEN_MAX = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] ONE_L   = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] ZERO_L  = '0;

    state_t        r_state;
    state_t        w_state_next;
    logic [AW:0]   r_rem;
    logic [AW:0]   r_beats;
    logic [AW-1:0] r_addr;
    logic [AW-1:0] r_dst_a;
    logic          r_inflight;
    logic [1:0]    r_count;
    logic          r_wptr;
    logic          r_rptr;
    logic          r_zero_done;
    logic [DW-1:0] r_mem [2];

    logic [AW:0]   w_len_clip;
    logic          w_start;
    logic          w_go;
    logic          w_pop;
    logic          w_push;
    logic [2:0]    w_occ;
    logic [AW-1:0] w_addr_inc;
    logic          w_cross;
    logic          w_issue;
    logic          w_last_pop;

    assign w_len_clip = (bus.len > LEN_MAX) ? LEN_MAX : bus.len;
    assign w_start    = (r_state == ST_IDLE) && bus.start;
    assign w_go       = w_start && (w_len_clip != ZERO_L);
    assign w_pop      = (r_count != 2'd0) && bus.m_ready;
    assign w_push     = r_inflight;
    // Occupancy the FIFO will have once this cycle's pop and capture settle.
    assign w_occ      = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_addr_inc = r_addr + {{(AW-1){1'b0}}, 1'b1};
    // While a word is being captured, dst_a must stay in that word's bank.
    assign w_cross    = r_inflight && (r_addr[AW-1] != r_dst_a[AW-1]);
    assign w_issue    = (r_state == ST_RUN) && (r_rem != ZERO_L) &&
                        (w_occ < 3'd2) && !w_cross;
    assign w_last_pop = w_pop && (r_beats == ONE_L);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_go)       w_state_next = ST_RUN;
            ST_RUN:  if (w_last_pop) w_state_next = ST_DONE;
            ST_DONE:                 w_state_next = ST_IDLE;
            default:                 w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_zero_done <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_zero_done <= w_start && (w_len_clip == ZERO_L);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem      <= '0;
            r_beats    <= '0;
            r_addr     <= '0;
            r_dst_a    <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_go) begin
                r_rem   <= w_len_clip;
                r_beats <= w_len_clip;
                r_addr  <= '0;
                r_dst_a <= '0;
            end else begin
                if (w_pop)
                    r_beats <= r_beats - ONE_L;
                if (w_issue) begin
                    r_rem  <= r_rem - ONE_L;
                    r_addr <= w_addr_inc;
                    // Hold dst_a across a bank boundary until the capture is done.
                    if (w_addr_inc[AW-1] == r_addr[AW-1])
                        r_dst_a <= w_addr_inc;
                end else if ((r_state == ST_RUN) && (r_rem != ZERO_L)) begin
                    r_dst_a <= r_addr;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= 2'd0;
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
        end else begin
            if (w_push)
                r_wptr <= ~r_wptr;
            if (w_pop)
                r_rptr <= ~r_rptr;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                r_mem[gi] <= '0;
            else if (w_push && (r_wptr == 1'(gi)))
                r_mem[gi] <= bus.dst_d;
        end
    end

    assign bus.busy    = (r_state == ST_RUN);
    assign bus.done    = (r_state == ST_DONE) || r_zero_done;
    assign bus.dst_v   = w_issue;
    assign bus.dst_a   = r_dst_a;
    assign bus.m_valid = (r_count != 2'd0);
    assign bus.m_data  = r_mem[r_rptr];
    assign bus.m_last  = (r_count != 2'd0) && (r_beats == ONE_L);
endmodule

// File: tb/tb_dst_stream_reader.sv
// Directed bench for dst_stream_reader with a two-bank registered-read buffer model.
module tb_dst_stream_reader;
    localparam int AW = 11;
    localparam int DW = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dst_stream_reader_if #(.AW(AW), .DW(DW)) bus ();
    dst_stream_reader #(.AW(AW), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] rd_lo, rd_hi;
    int vectors = 0;
    int miscompares = 0;

    function automatic logic [63:0] word(input int i);
        return 64'(i) * 64'h0101010101010101;
    endfunction

    initial for (int i = 0; i < 2**AW; i++) mem[i] = word(i);

    // Both banks read in parallel; output bank chosen by the current dst_a MSB.
    always @(posedge clk) begin
        if (bus.dst_v) begin
            rd_lo <= mem[{1'b0, bus.dst_a[AW-2:0]}];
            rd_hi <= mem[{1'b1, bus.dst_a[AW-2:0]}];
        end
    end
    assign bus.dst_d = bus.dst_a[AW-1] ? rd_hi : rd_lo;

    task automatic pulse_start(input logic [AW:0] l);
        @(negedge clk);
        bus.start = 1'b1;
        bus.len   = l;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; bus.start = 1'b0; bus.len = '0; bus.m_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        vectors++;
        if ({bus.busy, bus.done, bus.dst_v, bus.m_valid, bus.m_last} !== 5'b0) begin
            miscompares++; $display("FAIL reset_ctrl got %b want 00000", {bus.busy, bus.done, bus.dst_v, bus.m_valid, bus.m_last});
        end
        vectors++;
        if (bus.m_data !== 64'h0 || bus.dst_a !== 11'h0) begin
            miscompares++; $display("FAIL reset_data got data=%h addr=%h want 0", bus.m_data, bus.dst_a);
        end
        @(negedge clk); rst = 1'b0;
        @(negedge clk); #1;
        vectors++;
        if ({bus.busy, bus.done, bus.dst_v, bus.m_valid} !== 4'b0) begin
            miscompares++; $display("FAIL reset_release got %b want 0000", {bus.busy, bus.done, bus.dst_v, bus.m_valid});
        end
        $display("test_reset: done");
    endtask

    task automatic test_basic;
        bus.m_ready = 1'b1;
        pulse_start(12'd4); #1;
        vectors++;
        if (bus.busy !== 1'b1 || bus.dst_v !== 1'b1 || bus.dst_a !== 11'h0) begin
            miscompares++; $display("FAIL basic_issue got busy=%b dst_v=%b dst_a=%h want 1 1 000", bus.busy, bus.dst_v, bus.dst_a);
        end
        vectors++;
        if (bus.m_valid !== 1'b0) begin
            miscompares++; $display("FAIL basic_early_valid_e1 got %b want 0", bus.m_valid);
        end
        @(negedge clk); #1;
        vectors++;
        if (bus.m_valid !== 1'b0) begin
            miscompares++; $display("FAIL basic_early_valid_e2 got %b want 0", bus.m_valid);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            vectors++;
            if (bus.m_valid !== 1'b1 || bus.m_data !== word(k) || bus.m_last !== (k == 3)) begin
                miscompares++; $display("FAIL basic_beat%0d got v=%b d=%h l=%b want 1 %h %b", k, bus.m_valid, bus.m_data, bus.m_last, word(k), (k == 3));
            end
        end
        @(negedge clk); #1;
        vectors++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.m_valid !== 1'b0) begin
            miscompares++; $display("FAIL basic_done got done=%b busy=%b v=%b want 1 0 0", bus.done, bus.busy, bus.m_valid);
        end
        @(negedge clk); #1;
        vectors++;
        if (bus.done !== 1'b0) begin
            miscompares++; $display("FAIL basic_done_width got %b want 0", bus.done);
        end
        $display("test_basic: len=4 done");
    endtask

    task automatic test_len_zero;
        pulse_start(12'd0); #1;
        vectors++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.dst_v !== 1'b0) begin
            miscompares++; $display("FAIL zero_done got done=%b busy=%b dst_v=%b want 1 0 0", bus.done, bus.busy, bus.dst_v);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            vectors++;
            if ({bus.done, bus.dst_v, bus.m_valid, bus.busy} !== 4'b0) begin
                miscompares++; $display("FAIL zero_quiet%0d got %b want 0000", k, {bus.done, bus.dst_v, bus.m_valid, bus.busy});
            end
        end
        $display("test_len_zero: done");
    endtask

    task automatic test_full;
        int idx = 0, gaps = 0, gap_at = -1, last_cyc = -1, cyc = 0;
        bus.m_ready = 1'b1;
        pulse_start(12'd2048);
        while (idx < 2048 && cyc < 3000) begin
            #1;
            if (bus.m_valid) begin
                vectors++;
                if (bus.m_data !== word(idx) || bus.m_last !== (idx == 2047)) begin
                    miscompares++; $display("FAIL full_beat%0d got d=%h l=%b want %h %b", idx, bus.m_data, bus.m_last, word(idx), (idx == 2047));
                end
                if (idx > 0 && cyc - last_cyc != 1) begin
                    gaps++; gap_at = idx;
                end
                last_cyc = cyc;
                idx++;
            end
            @(negedge clk);
            cyc++;
        end
        #1;
        vectors++;
        if (idx !== 2048) begin
            miscompares++; $display("FAIL full_count got %0d want 2048", idx);
        end
        vectors++;
        if (gaps !== 1 || gap_at !== 1024) begin
            miscompares++; $display("FAIL full_bubble got gaps=%0d at=%0d want 1 at 1024", gaps, gap_at);
        end
        vectors++;
        if (bus.done !== 1'b1) begin
            miscompares++; $display("FAIL full_done got %b want 1", bus.done);
        end
        $display("test_full: len=2048 beats=%0d gaps=%0d", idx, gaps);
    endtask

    task automatic test_stall;
        logic [3:0] pat = 4'b1001;
        logic [DW-1:0] prev_data = '0;
        logic stalled = 1'b0;
        int idx = 0, cyc = 0, issued = 0, popped = 0;
        pulse_start(12'd8);
        while (idx < 8 && cyc < 200) begin
            bus.m_ready = pat[cyc % 4];
            #1;
            if (bus.dst_v) begin
                vectors++;
                if (issued - popped - int'(bus.m_valid && bus.m_ready) > 1) begin
                    miscompares++; $display("FAIL stall_overissue got outstanding=%0d want <=1 before issue", issued - popped - int'(bus.m_valid && bus.m_ready));
                end
                issued++;
            end
            if (stalled) begin
                vectors++;
                if (bus.m_valid !== 1'b1 || bus.m_data !== prev_data) begin
                    miscompares++; $display("FAIL stall_hold got v=%b d=%h want 1 %h", bus.m_valid, bus.m_data, prev_data);
                end
            end
            if (bus.m_valid && bus.m_ready) begin
                vectors++;
                if (bus.m_data !== word(idx) || bus.m_last !== (idx == 7)) begin
                    miscompares++; $display("FAIL stall_beat%0d got d=%h l=%b want %h %b", idx, bus.m_data, bus.m_last, word(idx), (idx == 7));
                end
                idx++; popped++;
            end
            stalled   = bus.m_valid && !bus.m_ready;
            prev_data = bus.m_data;
            @(negedge clk);
            cyc++;
        end
        bus.m_ready = 1'b1;
        #1;
        vectors++;
        if (idx !== 8 || issued !== 8 || bus.done !== 1'b1) begin
            miscompares++; $display("FAIL stall_end got beats=%0d issued=%0d done=%b want 8 8 1", idx, issued, bus.done);
        end
        $display("test_stall: len=8 beats=%0d issued=%0d", idx, issued);
    endtask

    task automatic test_reset_mid;
        int cyc = 0, idx = 0;
        bus.m_ready = 1'b1;
        pulse_start(12'd8);
        #1;
        while (!(bus.m_valid && bus.m_data === word(3)) && cyc < 20) begin
            @(negedge clk); #1;
            cyc++;
        end
        vectors++;
        if (cyc >= 20) begin
            miscompares++; $display("FAIL rstmid_reach got timeout want beat 3");
        end
        rst = 1'b1;
        #1;
        vectors++;
        if ({bus.busy, bus.done, bus.dst_v, bus.m_valid, bus.m_last} !== 5'b0 || bus.m_data !== 64'h0 || bus.dst_a !== 11'h0) begin
            miscompares++; $display("FAIL rstmid_clear got ctrl=%b d=%h a=%h want 0", {bus.busy, bus.done, bus.dst_v, bus.m_valid, bus.m_last}, bus.m_data, bus.dst_a);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            vectors++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                miscompares++; $display("FAIL rstmid_nodone%0d got done=%b busy=%b want 0 0", k, bus.done, bus.busy);
            end
        end
        pulse_start(12'd2);
        cyc = 0;
        while (idx < 2 && cyc < 20) begin
            #1;
            if (bus.m_valid) begin
                vectors++;
                if (bus.m_data !== word(idx) || bus.m_last !== (idx == 1)) begin
                    miscompares++; $display("FAIL rstmid_beat%0d got d=%h l=%b want %h %b", idx, bus.m_data, bus.m_last, word(idx), (idx == 1));
                end
                idx++;
            end
            @(negedge clk);
            cyc++;
        end
        #1;
        vectors++;
        if (idx !== 2 || bus.done !== 1'b1) begin
            miscompares++; $display("FAIL rstmid_restart got beats=%0d done=%b want 2 1", idx, bus.done);
        end
        $display("test_reset_mid: restart beats=%0d", idx);
    endtask

    task automatic test_start_busy;
        int cyc = 0, idx = 0;
        bus.m_ready = 1'b1;
        pulse_start(12'd5);
        while (idx < 5 && cyc < 40) begin
            if (cyc == 1) begin bus.start = 1'b1; bus.len = 12'd2; end
            if (cyc == 2) bus.start = 1'b0;
            #1;
            if (bus.m_valid) begin
                vectors++;
                if (bus.m_data !== word(idx) || bus.m_last !== (idx == 4)) begin
                    miscompares++; $display("FAIL busy_beat%0d got d=%h l=%b want %h %b", idx, bus.m_data, bus.m_last, word(idx), (idx == 4));
                end
                idx++;
            end
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        #1;
        vectors++;
        if (idx !== 5 || bus.done !== 1'b1) begin
            miscompares++; $display("FAIL busy_end got beats=%0d done=%b want 5 1", idx, bus.done);
        end
        @(negedge clk); #1;
        vectors++;
        if (bus.busy !== 1'b0 || bus.m_valid !== 1'b0) begin
            miscompares++; $display("FAIL busy_idle got busy=%b v=%b want 0 0", bus.busy, bus.m_valid);
        end
        $display("test_start_busy: beats=%0d", idx);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.len = '0;
        bus.m_ready = 1'b1;
        test_reset;
        test_basic;
        test_len_zero;
        test_full;
        test_stall;
        test_reset_mid;
        test_start_busy;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
